// File: rtl/booth_pkg.sv
// Shared types and constants for the Booth multiplier scheduler.
package booth_pkg;

    localparam int OP_W     = 16;
    localparam int PROD_W   = 32;
    localparam int LAT_FLAT = 1;
    localparam int LAT_PIPE = 2;
    // Tag ID field is sized for the largest supported requester count (8).
    localparam int TAG_ID_W = 3;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic                vld;
        logic [TAG_ID_W-1:0] id;
        logic                zero;
    } tag_t;

endpackage

// File: rtl/booth_resp_fifo.sv
// First-word fall-through response FIFO with occupancy count.
module booth_resp_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign do_push = push_i && (count_q != CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/booth_mul_sched.sv
// Round-robin scheduler sharing one external 16x16 Booth multiplier among N_REQ requesters.
// Define BOOTH_SCHED_STATS_EN to add saturating issued/bypassed counters with stat_clr.
module booth_mul_sched
    import booth_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int RESP_DEPTH = 4,
    parameter int ID_W       = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [OP_W*N_REQ-1:0] req_a,
    input  logic [OP_W*N_REQ-1:0] req_b,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic [PROD_W-1:0]     resp_prod,
    input  logic                  mode_req,
    output logic                  mode_ack,
    output logic                  mul_en,
    output logic [OP_W-1:0]       mul_a,
    output logic [OP_W-1:0]       mul_b,
    output logic                  mul_pipeline_en,
    input  logic [PROD_W-1:0]     mul_prod,
    output logic                  busy
`ifdef BOOTH_SCHED_STATS_EN
    ,
    input  logic                  stat_clr,
    output logic [31:0]           stat_issued,
    output logic [31:0]           stat_bypassed
`endif
);

    localparam int CNT_W  = $clog2(RESP_DEPTH + 1);
    localparam int FIFO_W = TAG_ID_W + PROD_W;

    sched_state_e      state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    tag_t              tag_q [2];
    tag_t              tag_d [2];
    logic              mul_en_q;
    logic [OP_W-1:0]   mul_a_q, mul_b_q;
    logic              pipe_en_q;
    logic              mode_ack_q;
    logic              do_switch;

    logic [2*N_REQ-1:0] vld_dbl;
    logic [N_REQ-1:0]   vld_rot;
    logic               gnt_found;
    logic [ID_W-1:0]    gnt_id;
    logic [OP_W-1:0]    sel_a, sel_b;
    logic               op_zero;
    logic               credit_ok;
    logic               can_issue;
    logic               issue;

    tag_t               cap_tag;
    logic [FIFO_W-1:0]  fifo_wdata, fifo_rdata;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_cnt;
    logic [TAG_ID_W-1:0] head_id;
    logic [PROD_W-1:0]  head_prod;

    // Rotate valids so the search starts at the RR pointer; lowest offset wins.
    always_comb begin
        vld_dbl   = {req_valid, req_valid};
        vld_rot   = N_REQ'(vld_dbl >> rr_ptr_q);
        gnt_found = 1'b0;
        gnt_id    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (vld_rot[k]) begin
                gnt_found = 1'b1;
                gnt_id    = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
            end
        end
    end

    assign sel_a   = OP_W'(req_a >> (int'(gnt_id) * OP_W));
    assign sel_b   = OP_W'(req_b >> (int'(gnt_id) * OP_W));
    assign op_zero = (sel_a == '0) || (sel_b == '0);

    // In-flight ops already hold a FIFO slot, so the FIFO can never overflow.
    assign credit_ok = (int'(fifo_cnt) + int'(tag_q[0].vld) + int'(tag_q[1].vld)) < RESP_DEPTH;
    assign can_issue = (state_q == ST_RUN) && (mode_req == mode_ack_q) && credit_ok;
    assign issue     = can_issue && gnt_found;
    assign req_ready = issue ? (N_REQ'(1) << gnt_id) : '0;

    always_comb begin
        state_d   = state_q;
        do_switch = 1'b0;
        case (state_q)
            ST_RUN:    if (mode_req != mode_ack_q) state_d = ST_DRAIN;
            ST_DRAIN:  if (!tag_q[0].vld && !tag_q[1].vld) state_d = ST_SWITCH;
            ST_SWITCH: begin
                do_switch = 1'b1;
                state_d   = ST_RUN;
            end
            default:   state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            pipe_en_q  <= 1'b0;
            mode_ack_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (do_switch) begin
                pipe_en_q  <= mode_req;
                mode_ack_q <= mode_req;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (issue) rr_ptr_d = (int'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + 1'b1;
    end

    // Tag pipe: stage 1 is only used when the multiplier is pipelined.
    always_comb begin
        tag_d[0] = '0;
        if (issue) tag_d[0] = '{vld: 1'b1, id: TAG_ID_W'(gnt_id), zero: op_zero};
        tag_d[1] = pipe_en_q ? tag_q[0] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            tag_q[0] <= '0;
            tag_q[1] <= '0;
            mul_en_q <= 1'b0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            tag_q[0] <= tag_d[0];
            tag_q[1] <= tag_d[1];
            mul_en_q <= issue && !op_zero;
            if (issue && !op_zero) begin
                mul_a_q <= sel_a;
                mul_b_q <= sel_b;
            end
        end
    end

    // Zero ops never enabled the multiplier, so its product is stale for them.
    assign cap_tag    = pipe_en_q ? tag_q[LAT_PIPE-1] : tag_q[LAT_FLAT-1];
    assign fifo_wdata = {cap_tag.id, (cap_tag.zero ? {PROD_W{1'b0}} : mul_prod)};

    booth_resp_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (cap_tag.vld),
        .wdata_i (fifo_wdata),
        .pop_i   (resp_valid && resp_ready),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign {head_id, head_prod} = fifo_rdata;
    assign resp_valid      = !fifo_empty;
    assign resp_id         = fifo_empty ? '0 : ID_W'(head_id);
    assign resp_prod       = fifo_empty ? '0 : head_prod;
    assign mul_en          = mul_en_q;
    assign mul_a           = mul_a_q;
    assign mul_b           = mul_b_q;
    assign mul_pipeline_en = pipe_en_q;
    assign mode_ack        = mode_ack_q;
    assign busy            = tag_q[0].vld || tag_q[1].vld || !fifo_empty || (state_q != ST_RUN);

`ifdef BOOTH_SCHED_STATS_EN
    logic [31:0] stat_issued_q;
    logic [31:0] stat_bypassed_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued_q   <= '0;
            stat_bypassed_q <= '0;
        end else if (stat_clr) begin
            stat_issued_q   <= '0;
            stat_bypassed_q <= '0;
        end else begin
            if (issue)            stat_issued_q   <= sat_inc(stat_issued_q);
            if (issue && op_zero) stat_bypassed_q <= sat_inc(stat_bypassed_q);
        end
    end

    assign stat_issued   = stat_issued_q;
    assign stat_bypassed = stat_bypassed_q;
`endif

endmodule

// File: doc/booth_mul_sched.md
Name: booth_mul_sched

Overview:
- Shares one external 16x16 radix-4 Booth multiplier among N_REQ requesters.
- Round-robin arbitration with valid/ready per requester; one issue per cycle.
- Tracks in-flight operations by fixed-latency tag pipeline and returns results in issue order, tagged with requester ID, through a credit-protected response FIFO.
- Manages the multiplier's pipeline mode: drains in-flight work before switching. Bypasses zero operands, because the multiplier gates its clock on zero and holds a stale product.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- RESP_DEPTH, 4, response FIFO entries (power of 2, >= 2)
- ID_W, 2, requester ID width, = clog2(N_REQ)

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester grant; a transfer occurs when valid & ready
- req_a  in  16*N_REQ  operand A, requester i at [16i+15:16i]
- req_b  in  16*N_REQ  operand B, same packing
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_id  out  ID_W  requester ID of result
- resp_prod  out  32  product
- mode_req  in  1  requested multiplier pipeline mode (0 = flat, 1 = pipelined)
- mode_ack  out  1  current applied mode
- mul_en  out  1  multiplier enable
- mul_a  out  16  multiplier operand A
- mul_b  out  16  multiplier operand B
- mul_pipeline_en  out  1  multiplier pipeline mode
- mul_prod  in  32  multiplier product
- busy  out  1  any request in flight or FIFO non-empty

Behaviour:
- Reset values: req_ready=0, resp_valid=0, resp_id=0, resp_prod=0, mul_en=0, mul_a=0, mul_b=0, mul_pipeline_en=0, mode_ack=0, busy=0. State=RUN, RR pointer=0, FIFO empty, tag pipe cleared.
- Latency L from issue to mul_prod valid: L=1 when mul_pipeline_en=0, L=2 when mul_pipeline_en=1.
- Tag pipe: 2 stages of {vld, id, zero}. Stage-0 is written on issue. The result is captured from stage L-1 into the FIFO.
- Arbitration: one-hot grant to the first valid requester at or after the RR pointer. The pointer moves to grant+1 mod N_REQ after each transfer.
- req_ready is combinational and is only asserted to the selected requester.
- Issue condition: state==RUN and (FIFO count + in-flight count) < RESP_DEPTH (credit rule). The FIFO therefore never overflows, and resp_ready may stall indefinitely.
- On issue: mul_a, mul_b and mul_en=1 are registered next cycle; otherwise mul_en=0 and mul_a/mul_b hold.
- Zero bypass: if a==0 or b==0, the op still occupies a tag slot (preserves order) with zero=1. mul_en is not asserted for it. The captured product is forced to 0.
- Response FIFO is first-word fall-through: resp_valid = !empty. Pop on resp_valid & resp_ready. A simultaneous push and pop when full is impossible under the credit rule.
- FSM:
  - RUN: if mode_req != mode_ack → DRAIN (no issue that cycle).
  - DRAIN: no issue; when the tag pipe is empty → SWITCH.
  - SWITCH: one cycle; mul_pipeline_en <= mode_req, mode_ack <= mode_req → RUN.
  - FIFO contents are unaffected by a mode change.
- busy = any tag vld | !FIFO empty | state != RUN.
- Async reset mid-operation: in-flight ops and FIFO contents are discarded; no response is emitted for them.

Optional Feature:
- BOOTH_SCHED_STATS_EN defined: adds outputs stat_issued[31:0] and stat_bypassed[31:0].
  - Saturating counters of issued ops and zero-bypassed ops.
  - Reset to 0.
  - Cleared synchronously by an added input stat_clr.
- Not defined: these ports and the counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package booth_pkg:
  - Latency constants LAT_FLAT=1, LAT_PIPE=2.
  - FSM state encoding RUN/DRAIN/SWITCH.
  - Tag struct {vld, id, zero}.
  - Operand width constant 16, product width constant 32.
- One sub-module: booth_resp_fifo (parameterised FWFT FIFO with count output).
- Arbiter and FSM stay in the top.

Test Plan:
- Single request, mode 0: req0 a=3, b=5 → one cycle later mul_en=1, mul_a=3, mul_b=5; resp id=0, prod=15 captured L=1 after issue; resp_valid next cycle.
- All 4 requesters valid continuously, resp_ready=1 → grants 0,1,2,3,0… one per cycle; responses in the same order with correct products (e.g. a=0xFFFF, b=0xFFFF → 0xFFFE0001 per multiplier semantics).
- Zero bypass: req1 a=0, b=0x1234 between two nonzero ops → mul_en=0 that cycle; resp id=1, prod=0 in order; mul_prod is ignored for that slot.
- Backpressure: resp_ready=0 with continuous requests → exactly RESP_DEPTH issues, then req_ready=0 everywhere; releasing resp_ready drains in order, and issuing resumes on a credit-by-credit basis.
- Mode switch with 2 ops in flight: mode_req 0→1 → no issue until the tag pipe is empty; then one SWITCH cycle; mul_pipeline_en=mode_ack=1; subsequent results use L=2.
- Reset mid-stream: rst_n low with FIFO holding 3 entries → all outputs go to reset values immediately; after release no stale response appears and the RR pointer is 0.
